lsu_align: RTL and testbench

Parametrised load/store alignment unit sitting between the CPU datapath and the L1 cache port. Accepts one byte/half/word(/double) load or store per request, generates byte enables and shifted write data, extracts and sign/zero-extends load data, and splits accesses that straddle a bus-word boundary into two back-to-back cache transactions. Replaces the combinational store-shift and load-extract muxes. Misaligned halves no longer return zero; they are either split or flagged as errors.

---
 rtl/lsu_align_if.sv | 56 +++++
 rtl/lsu_align.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu_align.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_align_if.sv
// -----------------------------------------------------------------------------
// lsu_align_if
//
// Bundles the CPU-side request/response handshake and the L1 cache port of
// the load/store alignment unit.
//
//   slave  modport : the alignment unit (takes requests, drives the cache port)
//   master modport : the environment (CPU datapath + cache)
//
// Signals
//   req_valid/req_ready           request handshake
//   req_store, req_funct3         operation: store flag, RV funct3 (size, unsigned)
//   req_addr, req_wdata           byte address, right-justified store data
//   resp_valid/resp_err           one-cycle completion pulse, error flag
//   resp_rdata                    extended load data
//   mem_read/mem_write            cache request, held until mem_resp
//   mem_address                   bus-word-aligned address
//   mem_byte_enable, mem_wdata    active lanes, lane-shifted store data
//   mem_rdata, mem_resp           cache read data and completion
// -----------------------------------------------------------------------------
interface lsu_align_if #(
    parameter int XLEN = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [XLEN-1:0]       req_wdata;

    logic                  resp_valid;
    logic                  resp_err;
    logic [XLEN-1:0]       resp_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_address;
    logic [XLEN/8-1:0]     mem_byte_enable;
    logic [XLEN-1:0]       mem_wdata;
    logic [XLEN-1:0]       mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//
// Load/store alignment unit between the CPU datapath and the L1 cache port.
// Accepts one B/H/W(/D) access per request, generates byte enables and
// lane-shifted store data, extracts and sign/zero-extends load data.
//
// Ports
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   lsu_align_if.slave (request/response handshake + cache port)
//
// Parameters
//   XLEN  data/bus width, 32 or 64
//
// Build option
//   LSU_MISALIGN_SPLIT_EN  when defined, accesses straddling a bus-word
//                          boundary are split into two back-to-back cache
//                          transactions; when undefined, any access that is
//                          not naturally aligned completes with resp_err.
//
// All outputs decode registered state only; request and cache inputs reach
// the outputs only through a clock edge.
// -----------------------------------------------------------------------------
module lsu_align #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_align_if.slave bus
);
    localparam int B   = XLEN / 8;
    localparam int OFS = $clog2(B);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int NW  = 2;   // bus words spanned by the lane vectors
`else
    localparam int NW  = 1;
`endif

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t          state_q, state_d;

    logic            store_q;
    logic [2:0]      funct3_q;
    logic [31:0]     addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            err_q;
    logic [XLEN-1:0] lo_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic            split_q;
    logic [XLEN-1:0] hi_q;
`endif

    // ------------------------------------------------------------------
    // Decode of the live request; only consumed in IDLE on accept.
    // ------------------------------------------------------------------
    logic [OFS-1:0] req_off;
    int             req_bytes;
    logic           req_illegal;
    logic           req_split;
    logic           req_err;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        req_off     = bus.req_addr[OFS-1:0];
        req_bytes   = 1 << bus.req_funct3[1:0];
        req_illegal = (bus.req_funct3 == 3'd7)
                   || (bus.req_store && bus.req_funct3[2])
                   || ((XLEN == 32) && (bus.req_funct3[1:0] == 2'd3));
        req_split   = (int'(req_off) + req_bytes) > B;
`ifdef LSU_MISALIGN_SPLIT_EN
        req_err     = req_illegal;
`else
        // Without splitting, anything not naturally aligned is rejected.
        req_err     = req_illegal || req_split
                   || ((int'(req_off) & (req_bytes - 1)) != 0);
`endif
    end

    // ------------------------------------------------------------------
    // Lane vectors built from the latched request. The vectors span NW
    // bus words; the low word feeds ACC0, the high word ACC1.
    // ------------------------------------------------------------------
    logic [OFS-1:0]     off;
    int                 nbytes;
    logic [31:0]        base_addr;
    logic [NW*B-1:0]    be_vec;
    logic [NW*XLEN-1:0] wd_vec;
    logic [NW*XLEN-1:0] rd_vec;
    logic [XLEN-1:0]    rd_shift;
    logic               sign_bit;
    logic [XLEN-1:0]    load_ext;

    always_comb begin
        off       = addr_q[OFS-1:0];
        nbytes    = 1 << funct3_q[1:0];
        base_addr = {addr_q[31:OFS], {OFS{1'b0}}};

        be_vec = '0;
        for (int i = 0; i < NW*B; i++) begin
            be_vec[i] = (i >= int'(off)) && (i < int'(off) + nbytes);
        end
        wd_vec = (NW*XLEN)'(wdata_q) << {off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
        rd_vec = {hi_q, lo_q};
`else
        rd_vec = lo_q;
`endif
        rd_shift = XLEN'(rd_vec >> {off, 3'b000});

        case (funct3_q[1:0])
            2'd0:    sign_bit = rd_shift[7];
            2'd1:    sign_bit = rd_shift[15];
            2'd2:    sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[XLEN-1];
        endcase

        // Bits above the access size take the sign for signed loads, else 0.
        for (int i = 0; i < XLEN; i++) begin
            load_ext[i] = (i < 8*nbytes) ? rd_shift[i] : (sign_bit & ~funct3_q[2]);
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d             = state_q;
        bus.req_ready       = 1'b0;
        bus.resp_valid      = 1'b0;
        bus.resp_err        = 1'b0;
        bus.resp_rdata      = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = '0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = req_err ? RESP : ACC0;
            end
            ACC0: begin
                bus.mem_read        = ~store_q;
                bus.mem_write       = store_q;
                bus.mem_address     = base_addr;
                bus.mem_byte_enable = be_vec[B-1:0];
                bus.mem_wdata       = store_q ? wd_vec[XLEN-1:0] : '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (bus.mem_resp) state_d = split_q ? ACC1 : RESP;
`else
                if (bus.mem_resp) state_d = RESP;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                bus.mem_read        = ~store_q;
                bus.mem_write       = store_q;
                bus.mem_address     = base_addr + 32'(B);   // wraps mod 2^32
                bus.mem_byte_enable = be_vec[2*B-1:B];
                bus.mem_wdata       = store_q ? wd_vec[2*XLEN-1:XLEN] : '0;
                if (bus.mem_resp) state_d = RESP;
            end
`endif
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                if (!err_q && !store_q) bus.resp_rdata = load_ext;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and read-data buffers
    // ------------------------------------------------------------------
    // NOTE: the data buffers are plain registers, so they are cleared on reset
    // along with the control state; nothing here is a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            lo_q     <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q  <= 1'b0;
            hi_q     <= '0;
`endif
        end else begin
            if (state_q == IDLE && bus.req_valid) begin
                store_q  <= bus.req_store;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                err_q    <= req_err;
`ifdef LSU_MISALIGN_SPLIT_EN
                split_q  <= req_split;
`endif
            end
            if (state_q == ACC0 && bus.mem_resp) lo_q <= bus.mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_q == ACC1 && bus.mem_resp) hi_q <= bus.mem_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// -----------------------------------------------------------------------------
// tb_lsu_align
//
// Self-checking bench for lsu_align at XLEN=32. A byte-addressed memory and a
// byte-level reference model predict, per request, the cache transactions
// (address, lanes, data), the load result, the error flag and the latency.
// The bench acts as the cache, answering each transaction after a random
// number of wait cycles. Follows LSU_MISALIGN_SPLIT_EN like the design.
// -----------------------------------------------------------------------------
module tb_lsu_align;
    localparam int XLEN = 32;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_align_if #(.XLEN(XLEN)) bus ();
    lsu_align #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference memory and model ----------------
    bit [7:0] mem [bit [31:0]];

    function automatic bit [7:0] rd_byte(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    typedef struct {
        bit [31:0] addr;
        bit [3:0]  be;
        bit [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];

    // Byte k of the access lives at byte address addr+k; the store data
    // window places wdata byte p at window offset off+p.
    task automatic model(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, output bit err, output bit [31:0] rdata);
        int        s, off, nw, p;
        bit        illegal, straddle, misal;
        bit [31:0] base;
        bit [63:0] val;
        txn_t      t;
        s        = 1 << f3[1:0];
        off      = int'(addr[1:0]);
        illegal  = (f3 == 3'd7) || (st && f3[2]) || (f3[1:0] == 2'd3);
        straddle = (off + s) > 4;
        misal    = (off % s) != 0;
        err      = illegal || (!SPLIT_EN && (straddle || misal));
        rdata    = '0;
        exp_q.delete();
        if (err) return;
        base = addr & ~32'h3;
        nw   = straddle ? 2 : 1;
        for (int j = 0; j < nw; j++) begin
            t.addr  = base + 32'(4*j);
            t.be    = '0;
            t.wdata = '0;
            for (int l = 0; l < 4; l++) begin
                p = 4*j + l - off;
                if (p >= 0 && p < s) t.be[l] = 1'b1;
                if (st && p >= 0 && p < 4) t.wdata[8*l +: 8] = wd[8*p +: 8];
            end
            exp_q.push_back(t);
        end
        if (st) begin
            for (int k = 0; k < s; k++) mem[addr + 32'(k)] = wd[8*k +: 8];
        end else begin
            val = '0;
            for (int k = 0; k < s; k++) val = val | (64'(rd_byte(addr + 32'(k))) << (8*k));
            if (!f3[2] && val[8*s-1]) val = val | ~((64'd1 << (8*s)) - 64'd1);
            rdata = val[31:0];
        end
    endtask

    // ---------------- one request, bench acting as the cache ----------------
    // Called and returns on a falling edge with the DUT idle.
    task automatic access(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                          input bit [31:0] wd, input int max_wait,
                          output bit [31:0] got_rd, output bit got_err);
        bit        exp_err;
        bit [31:0] exp_rd;
        int        waits[2];
        int        exp_lat, cyc, idx, waited;
        bit        done;
        model(st, f3, addr, wd, exp_err, exp_rd);
        waits[0] = $urandom_range(max_wait, 0);
        waits[1] = $urandom_range(max_wait, 0);
        exp_lat  = 1;
        if (!exp_err) exp_lat = 1 + exp_q.size() + waits[0] + ((exp_q.size() > 1) ? waits[1] : 0);

        check("idle_ready", bus.req_ready, 1'b1);
        check("idle_resp_valid", bus.resp_valid, 1'b0);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(negedge clk);
        cyc = 1; idx = 0; waited = 0; done = 1'b0;
        while (!done) begin
            // Junk on the request bus while busy must not be accepted.
            bus.req_valid  = 1'($urandom_range(1, 0));
            bus.req_store  = 1'($urandom_range(1, 0));
            bus.req_funct3 = 3'($urandom_range(7, 0));
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            bus.mem_resp   = 1'b0;
            check("busy_ready", bus.req_ready, 1'b0);
            if (bus.resp_valid) begin
                check("resp_err", bus.resp_err, exp_err);
                check("resp_rdata", bus.resp_rdata, exp_rd);
                check("latency", 64'(cyc), 64'(exp_lat));
                check("txn_count", 64'(idx), 64'(exp_q.size()));
                got_rd  = bus.resp_rdata;
                got_err = bus.resp_err;
                bus.req_valid = 1'b0;
                bus.mem_resp  = 1'($urandom_range(1, 0));   // must be ignored in RESP
                done = 1'b1;
            end else if (bus.mem_read || bus.mem_write) begin
                check("rw_exclusive", bus.mem_read & bus.mem_write, 1'b0);
                if (idx >= exp_q.size()) begin
                    check("unexpected_txn", 64'(idx), 64'(exp_q.size()));
                    bus.mem_resp = 1'b1;
                    idx++;
                end else begin
                    check("mem_write", bus.mem_write, st);
                    check("mem_address", bus.mem_address, exp_q[idx].addr);
                    check("mem_byte_enable", bus.mem_byte_enable, exp_q[idx].be);
                    check("mem_wdata", bus.mem_wdata, exp_q[idx].wdata);
                    if (waited >= waits[idx]) begin
                        for (int l = 0; l < 4; l++)
                            bus.mem_rdata[8*l +: 8] = rd_byte(bus.mem_address + 32'(l));
                        bus.mem_resp = 1'b1;
                        idx++;
                        waited = 0;
                    end else begin
                        waited++;
                    end
                end
            end else begin
                check("inactive_be", bus.mem_byte_enable, 4'h0);
            end
            if (!done) begin
                if (cyc > 30) begin
                    check("timeout_latency", 64'(cyc), 64'(exp_lat));
                    got_rd = '0; got_err = 1'b0;
                    bus.req_valid = 1'b0;
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        @(negedge clk);
        bus.mem_resp = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    bit [31:0] rd;
    bit        er;
    bit [31:0] bases[3] = '{32'h0000_1000, 32'h0000_3000, 32'hFFFF_FFF8};

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_rdata  = '0;
        bus.mem_resp   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_err", bus.resp_err, 1'b0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_address", bus.mem_address, 32'h0);
        check("rst_mem_be", bus.mem_byte_enable, 4'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // sb 0x1003 -> lane 3
        access(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 0, rd, er);
        check("sb_err", er, 1'b0);

        // lh / lhu at 0x2002 over word 0x8001_0000
        mem[32'h2000] = 8'h00; mem[32'h2001] = 8'h00;
        mem[32'h2002] = 8'h01; mem[32'h2003] = 8'h80;
        access(1'b0, 3'd1, 32'h0000_2002, 32'h0, 0, rd, er);
        check("lh_rdata", rd, 32'hFFFF_8001);
        access(1'b0, 3'd5, 32'h0000_2002, 32'h0, 1, rd, er);
        check("lhu_rdata", rd, 32'h0000_8001);

        // lw straddling 0x3003
        for (int k = 0; k < 8; k++) mem[32'h3000 + 32'(k)] = 8'(8'h11 * (k + 1));
        access(1'b0, 3'd2, 32'h0000_3003, 32'h0, 0, rd, er);
        check("lw_split_rdata", rd, SPLIT_EN ? 32'h7766_5544 : 32'h0);
        check("lw_split_err", er, !SPLIT_EN);

        // sw wrapping at the top of the address space, then read back
        access(1'b1, 3'd2, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 1, rd, er);
        check("sw_wrap_err", er, !SPLIT_EN);
        access(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 0, rd, er);
        check("lw_wrap_rdata", rd, SPLIT_EN ? 32'hDEAD_BEEF : 32'h0);

        // Illegal encodings
        access(1'b0, 3'd3, 32'h0000_1000, 32'h0, 0, rd, er);
        check("ld_xlen32_err", er, 1'b1);
        access(1'b0, 3'd7, 32'h0000_1000, 32'h0, 0, rd, er);
        check("f3_7_err", er, 1'b1);
        access(1'b1, 3'd4, 32'h0000_1000, 32'h12, 0, rd, er);
        check("store_unsigned_err", er, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            access(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
                   bases[$urandom_range(2, 0)] + 32'($urandom_range(15, 0)),
                   $urandom, 2, rd, er);
        end

        // Reset while ACC0 waits on the cache
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h0000_1000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort_pre_read", bus.mem_read, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_mem_read", bus.mem_read, 1'b0);
        check("abort_mem_address", bus.mem_address, 32'h0);
        check("abort_req_ready", bus.req_ready, 1'b1);
        check("abort_resp_valid", bus.resp_valid, 1'b0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = $urandom;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        check("late_resp_valid", bus.resp_valid, 1'b0);
        check("late_req_ready", bus.req_ready, 1'b1);
        check("late_mem_read", bus.mem_read, 1'b0);
        @(negedge clk);
        check("late_resp_valid2", bus.resp_valid, 1'b0);

        // Unit still works after the abort
        access(1'b0, 3'd1, 32'h0000_2002, 32'h0, 0, rd, er);
        check("post_abort_lh", rd, 32'hFFFF_8001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
